// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel/line counters with zero-latency sync, blanking and frame-tick decode.
// Optional macro VGA_PIXEL_DIV_EN: internal divide-by-two pixel enable for a 2x-pixel-rate clk.
module vga_timing_ctrl #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frameTick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic pixEn;
  logic adv_p0;

  // Pixel enable
`ifdef VGA_PIXEL_DIV_EN
  always_ff @(posedge clk) begin
    if (reset) pixEn <= 1'b0;
    else       pixEn <= ~pixEn;
  end
`else
  assign pixEn = 1'b1;
`endif

  // Counter stage: adv_p0 records that the counts moved on the last edge
  always_ff @(posedge clk) begin
    if (reset) begin
      hCount <= '0;
      vCount <= '0;
      adv_p0 <= 1'b0;
    end else begin
      adv_p0 <= pixEn;
      if (pixEn) begin
        if (hCount == H_LAST) begin
          hCount <= '0;
          vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
        end else begin
          hCount <= hCount + 10'd1;
        end
      end
    end
  end

  // Decode stage: combinational from the counters, forced idle while reset is held
  always_comb begin
    hSync     = 1'b1;
    vSync     = 1'b1;
    bright    = 1'b0;
    frameTick = 1'b0;
    if (!reset) begin
      hSync     = !((hCount >= HS_START) && (hCount <= HS_END));
      vSync     = !((vCount >= VS_START) && (vCount <= VS_END));
      bright    = (hCount < H_VIS) && (vCount < V_VIS);
      frameTick = adv_p0 && (hCount == 10'd0) && (vCount == V_VIS);
    end
  end

endmodule
